// File: rtl/i2c_pkg.sv
// Package: i2c_pkg
// Shared definitions for the multi-byte I2C write master.
//   state_t : transaction FSM states
//   PH_0..3 : quarter-period phase codes within one SCL bit
//   qdiv()  : system clocks per quarter SCL period
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  // Phase 0: SCL low, SDA updated; 1-2: SCL high (sample in 2); 3: SCL low.
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // A divider below one clock is meaningless, so very fast SCL requests
  // saturate at one tick per system clock.
  function automatic int qdiv(input int src, input int scl);
    int q;
    q = src / (4 * scl);
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Module: i2c_tick_gen
// Quarter-period divider for the I2C master. Emits a one-clock tick every
// QDIV enabled clocks and a 2-bit phase that advances on each tick.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart counter and phase at zero (new transaction)
//   enable     : count only while asserted
//   hold       : stall at the terminal count, suppressing the tick
//   tick       : one-clock strobe at terminal count
//   phase      : current quarter of the SCL bit (PH_0..PH_3)
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !hold && (cnt == TERM);

  // Hold only bites at the terminal count, so the phase boundary is what
  // gets delayed while the count inside a phase is left alone.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= '0;
      phase <= PH_0;
    end else if (enable) begin
      if (cnt == TERM) begin
        if (!hold) begin
          cnt   <= '0;
          phase <= phase + 2'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_multibyte.sv
// Module: i2c_master_multibyte
// I2C write master: START, 1..MAX_BYTES bytes MSB first with an ACK check
// after each, then STOP. A NACK aborts the remaining bytes, still issues
// STOP and reports the failing byte index.
// Optional feature macro: I2C_CLK_STRETCH_EN (open-drain SCL with slave
// clock stretching; otherwise SCL is push-pull).
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   start      : transaction request, honoured only while busy=0
//   num_bytes  : byte count (clamped to MAX_BYTES), sampled with start
//   wr_data    : payload, byte 0 in the top 8 bits, sampled with start
//   busy       : transaction in progress, includes the done cycle
//   done       : one-clock end-of-transaction pulse
//   ack_err    : last transaction saw a NACK, held until next start
//   nack_idx   : 0-based index of the NACKed byte
//   i2c_sclk   : SCL (inout only with I2C_CLK_STRETCH_EN)
//   i2c_sdat   : SDA, open drain
module i2c_master_multibyte
  import i2c_pkg::*;
#(
  parameter int CLK_SRC_FREQ = 27000000,
  parameter int I2C_FREQ     = 40000,
  parameter int MAX_BYTES    = 4,
  parameter int CNT_W        = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_bytes,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic [CNT_W-1:0]       nack_idx,
`ifdef I2C_CLK_STRETCH_EN
  inout  wire                    i2c_sclk,
`else
  output logic                   i2c_sclk,
`endif
  inout  wire                    i2c_sdat
);

  localparam int QDIV = qdiv(CLK_SRC_FREQ, I2C_FREQ);
  localparam int PW   = 8 * MAX_BYTES;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state, state_n;
  logic [PW-1:0]    shreg;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_idx;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] num_eff;
  logic             nack_q;
  logic             done_q;
  logic             scl_q, sda_low_q;
  logic             scl_n, sda_low_n;
  logic [1:0]       sda_sync;
  logic             tick;
  logic [1:0]       phase;
  logic             hold;
  logic             accept;

  logic load, shift, next_byte, sample_ack, set_err, done_set;

  // busy stays high through the done cycle so a start there is ignored.
  assign busy    = (state != IDLE) || done_q;
  assign done    = done_q;
  assign accept  = start && !busy;
  assign num_eff = (num_bytes > MAX_CNT) ? MAX_CNT : num_bytes;

  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync;

  assign i2c_sclk = scl_q ? 1'bz : 1'b0;

  // A slave holding SCL low keeps the bit from leaving phase 1.
  assign hold = (phase == PH_1) && !scl_sync[1] &&
                (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) scl_sync <= 2'b11;
    else       scl_sync <= {scl_sync[0], i2c_sclk};
  end
`else
  assign i2c_sclk = scl_q;
  assign hold     = 1'b0;
`endif

  // Two-flop synchroniser for the slave's ACK on SDA.
  always_ff @(posedge clk) begin
    if (reset) sda_sync <= 2'b11;
    else       sda_sync <= {sda_sync[0], i2c_sdat};
  end

  i2c_tick_gen #(
    .QDIV (QDIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state != IDLE),
    .hold   (hold),
    .tick   (tick),
    .phase  (phase)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode, datapath strobes and the pin pattern for the
  // current state/phase. Pins are registered below so they never glitch.
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    shift      = 1'b0;
    next_byte  = 1'b0;
    sample_ack = 1'b0;
    set_err    = 1'b0;
    done_set   = 1'b0;
    scl_n      = 1'b1;
    sda_low_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (num_eff == '0) done_set = 1'b1;
          else               state_n  = START;
        end
      end
      START: begin
        scl_n     = (phase != PH_3);
        sda_low_n = (phase != PH_0);
        if (tick && phase == PH_3) state_n = BIT;
      end
      BIT: begin
        scl_n     = (phase == PH_1) || (phase == PH_2);
        sda_low_n = !shreg[PW-1];
        if (tick && phase == PH_3) begin
          shift = 1'b1;
          if (bit_cnt == 3'd7) state_n = ACK;
        end
      end
      ACK: begin
        scl_n = (phase == PH_1) || (phase == PH_2);
        if (tick && phase == PH_2) sample_ack = 1'b1;
        if (tick && phase == PH_3) begin
          if (nack_q) begin
            set_err = 1'b1;
            state_n = STOP;
          end else if (byte_idx == num_q - 1'b1) begin
            state_n = STOP;
          end else begin
            next_byte = 1'b1;
            state_n   = BIT;
          end
        end
      end
      STOP: begin
        scl_n     = (phase != PH_0);
        sda_low_n = (phase != PH_3);
        if (tick && phase == PH_3) state_n = DONE;
      end
      DONE: begin
        done_set = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: payload shifter, counters, ACK capture, status and pins.
  // Shifting on every data bit leaves the next byte at the top after
  // eight bits, so no separate byte select is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      num_q     <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err   <= 1'b0;
      nack_idx  <= '0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      done_q    <= done_set;
      scl_q     <= scl_n;
      sda_low_q <= sda_low_n;
      if (load) begin
        shreg    <= wr_data;
        bit_cnt  <= '0;
        byte_idx <= '0;
        num_q    <= num_eff;
        nack_q   <= 1'b0;
        ack_err  <= 1'b0;
        nack_idx <= '0;
      end
      if (shift) begin
        shreg   <= {shreg[PW-2:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (next_byte)  byte_idx <= byte_idx + 1'b1;
      if (sample_ack) nack_q   <= sda_sync[1];
      if (set_err) begin
        ack_err  <= 1'b1;
        nack_idx <= byte_idx;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_multibyte.sv
// Testbench: tb_i2c_master_multibyte
// Drives transactions into i2c_master_multibyte, models an I2C slave that
// decodes the bus and ACKs/NACKs, and scores bytes and completion status
// against queues filled when each transaction is launched.
module tb_i2c_master_multibyte;

  localparam int CLK_SRC_FREQ = 4000000;
  localparam int I2C_FREQ     = 100000;
  localparam int MAX_BYTES    = 4;
  localparam int CNT_W        = 3;
  localparam int Q            = CLK_SRC_FREQ / (4 * I2C_FREQ);

  typedef struct {
    logic       ack_err;
    logic [2:0] nack_idx;
    int         lat;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  num_bytes = '0;
  logic [31:0] wr_data = '0;
  logic        busy, done, ack_err;
  logic [2:0]  nack_idx;
  wire         i2c_sclk;
  wire         i2c_sdat;
  logic        slave_drive = 1'b0;

  pullup (i2c_sdat);
`ifdef I2C_CLK_STRETCH_EN
  pullup (i2c_sclk);
`endif
  assign i2c_sdat = slave_drive ? 1'b0 : 1'bz;

  i2c_master_multibyte #(
    .CLK_SRC_FREQ (CLK_SRC_FREQ),
    .I2C_FREQ     (I2C_FREQ),
    .MAX_BYTES    (MAX_BYTES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_bytes (num_bytes),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .nack_idx  (nack_idx),
    .i2c_sclk  (i2c_sclk),
    .i2c_sdat  (i2c_sdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  res_t       exp_res[$];

  logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_v, sda_v;
  logic       in_xfer = 1'b0, ack_phase = 1'b0;
  logic [7:0] rx = '0;
  int         bit_cnt = 0, byte_cnt = 0, bus_changes = 0;
  int         start_cnt = 0, stop_cnt = 0, done_cnt = 0;
  int         nack_at = -1, accept_cyc = 0;
  res_t       r;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model and completion scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    scl_v = i2c_sclk;
    sda_v = i2c_sdat;
    if (reset) begin
      in_xfer     = 1'b0;
      ack_phase   = 1'b0;
      bit_cnt     = 0;
      byte_cnt    = 0;
      slave_drive = 1'b0;
    end else begin
      if (scl_v !== prev_scl || sda_v !== prev_sda) bus_changes++;
      if (prev_scl && scl_v && prev_sda && !sda_v) begin
        in_xfer   = 1'b1;
        bit_cnt   = 0;
        byte_cnt  = 0;
        ack_phase = 1'b0;
        start_cnt++;
      end else if (prev_scl && scl_v && !prev_sda && sda_v) begin
        in_xfer = 1'b0;
        stop_cnt++;
      end else if (in_xfer && !prev_scl && scl_v && bit_cnt < 8) begin
        rx = {rx[6:0], sda_v};
        bit_cnt++;
        if (bit_cnt == 8) begin
          checkOutput("rx_byte_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0)
            checkOutput($sformatf("rx_byte%0d", byte_cnt), rx, exp_bytes.pop_front());
        end
      end else if (in_xfer && prev_scl && !scl_v && bit_cnt == 8) begin
        if (!ack_phase) begin
          ack_phase   = 1'b1;
          slave_drive = (byte_cnt != nack_at);
        end else begin
          ack_phase   = 1'b0;
          slave_drive = 1'b0;
          bit_cnt     = 0;
          byte_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_expected", exp_res.size() > 0, 1);
        if (exp_res.size() > 0) begin
          r = exp_res.pop_front();
          checkOutput("latency", cyc - accept_cyc, r.lat);
          checkOutput("ack_err", ack_err, r.ack_err);
          if (r.ack_err) checkOutput("nack_idx", nack_idx, r.nack_idx);
          checkOutput("bytes_left", exp_bytes.size(), 0);
          checkOutput("busy_in_done", busy, 1);
        end
      end
    end
    prev_scl = scl_v;
    prev_sda = sda_v;
  end

  // Queue the bytes the slave should see and the completion result, then
  // pulse start for one cycle. Acceptance happens on the following edge.
  task automatic applyStimulus(input int n, input logic [31:0] data, input int nack_i);
    int   eff, sent;
    res_t e;
    eff        = (n > MAX_BYTES) ? MAX_BYTES : n;
    sent       = 0;
    e.ack_err  = 1'b0;
    e.nack_idx = '0;
    for (int i = 0; i < eff; i++) begin
      exp_bytes.push_back(data[31-8*i -: 8]);
      sent++;
      if (i == nack_i) begin
        e.ack_err  = 1'b1;
        e.nack_idx = 3'(i);
        break;
      end
    end
    // Zero-byte requests finish in the cycle right after start was high.
    e.lat = (eff == 0) ? 0 : (8 + 36 * sent) * Q + 1;
    exp_res.push_back(e);
    @(negedge clk);
    nack_at    = nack_i;
    num_bytes  = 3'(n);
    wr_data    = data;
    start      = 1'b1;
    accept_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int base, input int limit);
    int k;
    k = 0;
    while (done_cnt == base && k < limit) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    checkOutput("done_seen", done_cnt - base, 1);
  endtask

  initial begin
    int b, bc, sb, k;

    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: bus released and quiet, status cleared.
    bc = bus_changes;
    repeat (1000) @(negedge clk);
    checkOutput("idle_scl", i2c_sclk, 1);
    checkOutput("idle_sda", i2c_sdat, 1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_ack_err", ack_err, 0);
    checkOutput("idle_nack_idx", nack_idx, 0);
    checkOutput("idle_bus_quiet", bus_changes - bc, 0);

    // Three bytes, all ACKed.
    b  = done_cnt;
    sb = stop_cnt;
    bc = start_cnt;
    applyStimulus(3, 32'h341E00AA, -1);
    waitDone(b, 5000);
    checkOutput("t2_starts", start_cnt - bc, 1);
    checkOutput("t2_stops", stop_cnt - sb, 1);

    // NACK on byte 1: byte 2 never appears, STOP still issued.
    b  = done_cnt;
    sb = stop_cnt;
    applyStimulus(3, 32'hA55AC300, 1);
    waitDone(b, 5000);
    checkOutput("t3_stops", stop_cnt - sb, 1);
    repeat (50) @(negedge clk);
    checkOutput("ack_err_held", ack_err, 1);
    checkOutput("nack_idx_held", nack_idx, 1);

    // Starts while busy and in the done cycle are both dropped.
    b = done_cnt;
    applyStimulus(1, 32'h7E000000, -1);
    repeat (100) @(negedge clk);
    num_bytes = 3'd2;
    wr_data   = 32'hFFFFFFFF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    bc    = bus_changes;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("t4_single_done", done_cnt - b, 1);
    checkOutput("t4_bus_quiet", bus_changes - bc, 0);
    checkOutput("t4_busy_after", busy, 0);
    checkOutput("t4_ack_err_cleared", ack_err, 0);

    // Zero bytes: immediate done, bus untouched.
    b  = done_cnt;
    bc = bus_changes;
    applyStimulus(0, 32'hDEADBEEF, -1);
    waitDone(b, 20);
    repeat (20) @(negedge clk);
    checkOutput("n0_bus_quiet", bus_changes - bc, 0);

    // Oversized count clamps to MAX_BYTES.
    b = done_cnt;
    applyStimulus(7, 32'h0180FF55, -1);
    waitDone(b, 5000);

    // Reset in the middle of byte 1: bus released at once, no done.
    b = done_cnt;
    applyStimulus(3, 32'hC3C3C3C3, -1);
    k = 0;
    while (!(byte_cnt == 1 && bit_cnt == 3) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_reached_byte1", (byte_cnt == 1 && bit_cnt == 3), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_scl", i2c_sclk, 1);
    checkOutput("rst_sda", i2c_sdat, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    exp_bytes.delete();
    exp_res.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("rst_no_done", done_cnt - b, 0);

    // Recovery, with the very first byte NACKed.
    b = done_cnt;
    applyStimulus(2, 32'h5A3C0000, 0);
    waitDone(b, 5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
